fp64_division: RTL and testbench
================================

# fp64_division

Sequential IEEE-754 double-precision divider: the inverse operation of the team's two-stage FP64 multiplier, sharing its operand format, flag set and flush/saturate policy. Computes a_operand / b_operand with a radix-2 restoring mantissa divider, one quotient bit per cycle. Uses a start/done handshake so the FPU top can issue a divide and keep the multiplier pipeline running in parallel.

## Interface
- No parameters; widths are fixed at FP64.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only while busy=0
- a_operand  input  64  dividend, captured on the accepted start edge
- b_operand  input  64  divisor, captured on the accepted start edge
- busy  output  1  high from the accepting edge until the done edge
- done  output  1  one-cycle pulse: result and flags valid
- result  output  64  quotient; holds until the next completion
- Exception  output  1  either operand has exponent 0x7FF
- Overflow  output  1  result exponent ≥ 2047
- Underflow  output  1  result exponent ≤ 0
- DivByZero  output  1  divisor is zero and no Exception

## Operation
- States: IDLE, DIV, FINISH.
- IDLE + start: capture sign = a[63]^b[63], ea, eb, and 53-bit mantissas {1,frac}.
- Operand with exponent 0 is flushed to zero; subnormals are not supported.
- Special cases, resolved at the capture edge, go straight to FINISH. Priority, highest first:
  - Exception: result 0.
  - b zero: DivByZero=1, result {sign,0x7FF,52'd0}.
  - a zero: result {sign,63'd0}.
- Otherwise go to DIV: remainder R (55 bits) = ma, iteration counter = 54.
- DIV, each cycle: if R ≥ mb then q bit = 1 and R −= mb, else q bit = 0; R <<= 1; q shifts in MSB-first. Leave for FINISH when the counter reaches 0, giving a 55-bit q.
- FINISH:
  - If q[54]=1: mantissa = q[53:2], round bit = q[1], exp = ea − eb + 1023.
  - Else: mantissa = q[52:1], round bit = q[0], exp = ea − eb + 1022.
  - Round half-up: mantissa + round bit. A carry out of the mantissa sets mantissa to 0 and adds 1 to exp.
  - Exponent math is 13-bit signed.
  - Overflow: result {sign,0x7FF,0}. Underflow: result {sign,63'd0}.
  - Otherwise result = {sign, exp[10:0], mantissa}.
- Flags are mutually exclusive and are registered together with result.

## Timing
- Reset values: busy=0, done=0, result=0, all flags 0, state IDLE.
- Start accepted at edge E: busy=1 after E.
  - Normal divide: 55 DIV edges (E+1..E+55), FINISH edge E+56. done=1 and result valid in the cycle after E+56.
  - Special case: done after edge E+1.
- busy falls on the same edge that raises done.
- start with busy=1 is ignored; it is not queued.
- start on the cycle done is high is accepted, because busy=0 then.
- A new start does not clear result or flags; they change only at the next done.
- Reset asserted mid-divide: immediate return to IDLE, all outputs to reset values, no done pulse.

## Structure
- Shared package fp64_pkg holds:
  - EXP_BIAS=1023, EXP_MAX=2047
  - MANT_W=52, DIV_ITER=55
  - the state enum
  - the QNaN/Inf/zero field constants
- Sub-module mant_div_radix2 holds the R/q registers, the counter, and the compare-subtract step. Its handshake is load/step/last.
- The top holds the FSM, special-case decode, normalise/round and flag logic.

## Test plan
- 0x4018000000000000 / 0x4000000000000000 → result 0x4008000000000000, flags 0, done 56 cycles after the start edge.
- 0x3FF0000000000000 / 0x4008000000000000 → 0x3FD5555555555555; 0xC010000000000000 / 0x4000000000000000 → 0xC000000000000000.
- 0x3FF0000000000000 / 0x0000000000000000 → 0x7FF0000000000000, DivByZero=1, done after 1 cycle.
- a=0x7FF0000000000000 → Exception=1, result 0, done after 1 cycle. 0x7FE0000000000000 / 0x3FE0000000000000 → Overflow=1, result 0x7FF0000000000000.
- 0x0010000000000000 / 0x4000000000000000 → Underflow=1, result 0x0000000000000000.
- start pulsed at cycle 10 of a busy divide is ignored, and the first result is unchanged. reset_n low at cycle 30 → busy=0, no done pulse. A divide started after release completes normally.

Source files
------------

// File: rtl/fp64_pkg.sv
// Shared FP64 field widths, constants and types used by the divide datapath.
package fp64_pkg;

    localparam int unsigned EXP_W    = 11;
    localparam int unsigned MANT_W   = 52;
    localparam int unsigned SIG_W    = MANT_W + 1;
    localparam int unsigned DIV_ITER = 55;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned EXPC_W   = 13;
    localparam int unsigned EXP_BIAS = 1023;
    localparam int unsigned EXP_MAX  = 2047;

    localparam logic [EXP_W-1:0]  EXP_SPECIAL = 11'h7FF;
    localparam logic [EXP_W-1:0]  EXP_ZERO    = 11'h000;
    localparam logic [MANT_W-1:0] FRAC_ZERO   = 52'd0;
    localparam logic [MANT_W-1:0] FRAC_QNAN   = {1'b1, 51'd0};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FINISH
    } div_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp64_t;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
        logic div_by_zero;
    } fp_flags_t;

endpackage

// File: rtl/mant_div_radix2.sv
// Radix-2 restoring mantissa divider: one quotient bit per step, MSB first.
module mant_div_radix2
    import fp64_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                step,
    input  logic [SIG_W-1:0]    dividend,
    input  logic [SIG_W-1:0]    divisor,
    output logic [DIV_ITER-1:0] quotient,
    output logic                last
);

    localparam int unsigned REM_W = DIV_ITER;

    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_sub_c;
    logic [REM_W-1:0] rem_next_c;
    logic [SIG_W-1:0] divisor_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ge_c;

    // Compare-subtract, then shift the partial remainder left
    always_comb begin
        ge_c       = rem_q >= REM_W'(divisor_q);
        rem_sub_c  = rem_q - REM_W'(divisor_q);
        rem_next_c = REM_W'({(ge_c ? rem_sub_c : rem_q), 1'b0});
    end

    // last is high while the counter sits at zero, i.e. during the final step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q     <= '0;
            divisor_q <= '0;
            quotient  <= '0;
            cnt_q     <= '0;
            last      <= 1'b0;
        end else if (load) begin
            rem_q     <= REM_W'(dividend);
            divisor_q <= divisor;
            quotient  <= '0;
            cnt_q     <= CNT_W'(DIV_ITER - 1);
            last      <= 1'b0;
        end else if (step) begin
            rem_q     <= rem_next_c;
            quotient  <= {quotient[DIV_ITER-2:0], ge_c};
            cnt_q     <= cnt_q - CNT_W'(1);
            last      <= (cnt_q == CNT_W'(1));
        end
    end

endmodule

// File: rtl/fp64_division.sv
// Sequential FP64 divider with start/done handshake; special operands resolve in one cycle.
module fp64_division
    import fp64_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] a_operand,
    input  logic [63:0] b_operand,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    div_state_e state_q, state_d;
    logic       busy_d, done_d, load_c, step_c, fin_c, capture_c;

    fp64_t      a_c, b_c;
    logic       sign_c, special_c;
    fp64_t      spec_res_c;
    fp_flags_t  spec_flags_c;

    logic             sign_q, spec_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    fp64_t            spec_res_q;
    fp_flags_t        spec_flags_q;

    logic [DIV_ITER-1:0]      quot;
    logic                     last;
    logic                     q_top_c, carry_c;
    logic [SIG_W-1:0]         mant_rnd_c;
    logic signed [EXPC_W-1:0] exp_c;
    fp64_t                    norm_res_c, fin_res_c;
    fp_flags_t                norm_flags_c, fin_flags_c;

    assign a_c = fp64_t'(a_operand);
    assign b_c = fp64_t'(b_operand);

    // Special-operand decode, highest priority first
    always_comb begin
        sign_c       = a_c.sign ^ b_c.sign;
        special_c    = 1'b1;
        spec_res_c   = '0;
        spec_flags_c = '0;
        if (a_c.exp == EXP_SPECIAL || b_c.exp == EXP_SPECIAL) begin
            spec_flags_c.exception = 1'b1;
        end else if (b_c.exp == EXP_ZERO) begin
            spec_flags_c.div_by_zero = 1'b1;
            spec_res_c = '{sign: sign_c, exp: EXP_SPECIAL, frac: FRAC_ZERO};
        end else if (a_c.exp == EXP_ZERO) begin
            spec_res_c.sign = sign_c;
        end else begin
            special_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy;
        done_d    = 1'b0;
        load_c    = 1'b0;
        step_c    = 1'b0;
        fin_c     = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture_c = 1'b1;
                    busy_d    = 1'b1;
                    if (special_c) begin
                        state_d = FINISH;
                    end else begin
                        load_c  = 1'b1;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                step_c = 1'b1;
                if (last) state_d = FINISH;
            end
            FINISH: begin
                fin_c   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q       <= 1'b0;
            spec_q       <= 1'b0;
            ea_q         <= '0;
            eb_q         <= '0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
        end else if (capture_c) begin
            sign_q       <= sign_c;
            spec_q       <= special_c;
            ea_q         <= a_c.exp;
            eb_q         <= b_c.exp;
            spec_res_q   <= spec_res_c;
            spec_flags_q <= spec_flags_c;
        end
    end

    mant_div_radix2 u_mant_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_c),
        .step     (step_c),
        .dividend ({1'b1, a_c.frac}),
        .divisor  ({1'b1, b_c.frac}),
        .quotient (quot),
        .last     (last)
    );

    // Normalise on the quotient MSB, round half-up, then range-check the exponent
    always_comb begin
        q_top_c    = quot[DIV_ITER-1];
        mant_rnd_c = q_top_c ? ({1'b0, quot[53:2]} + SIG_W'(quot[1]))
                             : ({1'b0, quot[52:1]} + SIG_W'(quot[0]));
        carry_c    = mant_rnd_c[MANT_W];
        exp_c      = $signed(EXPC_W'(ea_q) - EXPC_W'(eb_q) + EXPC_W'(EXP_BIAS)
                             - EXPC_W'(!q_top_c) + EXPC_W'(carry_c));
        norm_flags_c = '0;
        norm_res_c   = '{sign: sign_q, exp: exp_c[EXP_W-1:0], frac: mant_rnd_c[MANT_W-1:0]};
        if (exp_c >= $signed(EXPC_W'(EXP_MAX))) begin
            norm_flags_c.overflow = 1'b1;
            norm_res_c = '{sign: sign_q, exp: EXP_SPECIAL, frac: FRAC_ZERO};
        end else if (exp_c <= $signed(EXPC_W'(0))) begin
            norm_flags_c.underflow = 1'b1;
            norm_res_c = '{sign: sign_q, exp: EXP_ZERO, frac: FRAC_ZERO};
        end
        fin_res_c   = spec_q ? spec_res_q   : norm_res_c;
        fin_flags_c = spec_q ? spec_flags_q : norm_flags_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (fin_c) begin
                result    <= fin_res_c;
                Exception <= fin_flags_c.exception;
                Overflow  <= fin_flags_c.overflow;
                Underflow <= fin_flags_c.underflow;
                DivByZero <= fin_flags_c.div_by_zero;
            end
        end
    end

endmodule

// File: tb/tb_fp64_division.sv
// Bench for fp64_division: directed table, handshake corner sequences and random vs reference model.
module tb_fp64_division;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a_operand = '0;
    logic [63:0] b_operand = '0;
    logic        busy, done;
    logic [63:0] result;
    logic        Exception, Overflow, Underflow, DivByZero;

    always #5 clk = ~clk;

    fp64_division dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .DivByZero (DivByZero)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs [13];
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_EXC  = 4'b1000;
    localparam logic [3:0] F_OVF  = 4'b0100;
    localparam logic [3:0] F_UNF  = 4'b0010;
    localparam logic [3:0] F_DBZ  = 4'b0001;

    function automatic logic [3:0] flags_now();
        return {Exception, Overflow, Underflow, DivByZero};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: exact integer quotient of the significands, then IEEE-style field assembly
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic [3:0] f, output int lat);
        logic [10:0]  ea, eb;
        logic         s;
        logic [127:0] num, den, q, frac_full;
        int           sh, e;
        ea = a[62:52];
        eb = b[62:52];
        s  = a[63] ^ b[63];
        r  = '0;
        f  = F_NONE;
        lat = 1;
        if (ea == 11'h7FF || eb == 11'h7FF) begin
            f = F_EXC;
        end else if (eb == 11'h0) begin
            f = F_DBZ;
            r = {s, 11'h7FF, 52'd0};
        end else if (ea == 11'h0) begin
            r = {s, 63'd0};
        end else begin
            lat = 56;
            num = {75'd0, 1'b1, a[51:0]} << 54;
            den = {75'd0, 1'b1, b[51:0]};
            q   = num / den;
            sh  = q[54] ? 2 : 1;
            frac_full = (q >> sh) + ((q >> (sh - 1)) & 128'd1);
            e = int'(ea) - int'(eb) + 1021 + sh;
            if (frac_full[53]) begin
                e = e + 1;
                frac_full = '0;
            end
            if (e >= 2047) begin
                f = F_OVF;
                r = {s, 11'h7FF, 52'd0};
            end else if (e <= 0) begin
                f = F_UNF;
                r = {s, 63'd0};
            end else begin
                r = {s, 11'(e), frac_full[51:0]};
            end
        end
    endfunction

    task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        f = flags_now();
    endtask

    task automatic check_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] er, input logic [3:0] ef, input int el);
        logic [63:0] r;
        logic [3:0]  f;
        int          lat;
        run_div(a, b, r, f, lat);
        chk({tag, "_result"}, r, er);
        chk({tag, "_flags"}, 64'(f), 64'(ef));
        chk({tag, "_latency"}, 64'(lat), 64'(el));
    endtask

    initial begin
        int lat;
        int extra_done;
        logic [63:0] ra, rb, er;
        logic [3:0]  ef;
        int          el;

        vecs[0]  = '{64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, F_NONE, 56};
        vecs[1]  = '{64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, F_NONE, 56};
        vecs[2]  = '{64'hC010000000000000, 64'h4000000000000000, 64'hC000000000000000, F_NONE, 56};
        vecs[3]  = '{64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, F_DBZ, 1};
        vecs[4]  = '{64'h7FF0000000000000, 64'h4000000000000000, 64'h0000000000000000, F_EXC, 1};
        vecs[5]  = '{64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, F_OVF, 56};
        vecs[6]  = '{64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, F_UNF, 56};
        vecs[7]  = '{64'h0000000000000000, 64'h4000000000000000, 64'h0000000000000000, F_NONE, 1};
        vecs[8]  = '{64'hBFF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000, F_DBZ, 1};
        vecs[9]  = '{64'h0000000000000000, 64'h0000000000000000, 64'h7FF0000000000000, F_DBZ, 1};
        vecs[10] = '{64'h7FF8000000000000, 64'h0000000000000000, 64'h0000000000000000, F_EXC, 1};
        vecs[11] = '{64'h3FF0000000000000, 64'h3FF0000000000001, 64'h3FEFFFFFFFFFFFFE, F_NONE, 56};
        vecs[12] = '{64'h8000000000000000, 64'h4000000000000000, 64'h8000000000000000, F_NONE, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_flags", 64'(flags_now()), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            check_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, vecs[i].lat);
        end

        // Result and flags hold while the next divide runs
        check_div("hold_first", 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, F_NONE, 56);
        @(negedge clk);
        a_operand = 64'h3FF0000000000000;
        b_operand = 64'h4008000000000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_result", result, 64'h4008000000000000);
        chk("hold_flags", 64'(flags_now()), 64'd0);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_second_result", result, 64'h3FD5555555555555);

        // start while busy is dropped, not queued
        @(negedge clk);
        a_operand = 64'h4018000000000000;
        b_operand = 64'h4000000000000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) begin
                a_operand = 64'h3FF0000000000000;
                b_operand = 64'h0000000000000000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("ignore_latency", 64'(lat), 64'd56);
        chk("ignore_result", result, 64'h4008000000000000);
        chk("ignore_flags", 64'(flags_now()), 64'd0);
        extra_done = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        chk("ignore_no_extra_done", 64'(extra_done), 64'd0);
        chk("ignore_idle_busy", 64'(busy), 64'd0);

        // Reset mid-divide aborts with no done pulse
        @(negedge clk);
        a_operand = 64'h3FF0000000000000;
        b_operand = 64'h4008000000000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_flags", 64'(flags_now()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        extra_done = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        chk("abort_no_done", 64'(extra_done), 64'd0);
        check_div("after_abort", 64'hC010000000000000, 64'h4000000000000000, 64'hC000000000000000, F_NONE, 56);

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            ra[62:52] = 11'($urandom_range(1, 2046));
            rb[62:52] = 11'($urandom_range(1, 2046));
            if (i % 8 == 0) ra[62:52] = 11'h000;
            if (i % 8 == 4) rb[62:52] = 11'h7FF;
            if (i % 8 == 6) rb[62:52] = 11'h000;
            if (i % 8 == 2) rb[62:52] = ra[62:52];
            ref_div(ra, rb, er, ef, el);
            check_div($sformatf("rand%0d", i), ra, rb, er, ef, el);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
